// File: rtl/ssio_ddr_out.sv
// ssio_ddr_out: source-synchronous DDR transmit path with forwarded clock
// and a per-lane output-delay tap controller that gates VT compensation.
module ssio_ddr_out #(
  parameter int WIDTH         = 1,
  parameter bit CLOCK_INVERT  = 1'b0,
  parameter int VTC_WAIT      = 10,
  parameter int SETTLE_CYCLES = 8,
  parameter int TAP_MAX       = 511
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   input_d1,
  input  logic [WIDTH-1:0]   input_d2,
  output logic               output_clk,
  output logic [WIDTH-1:0]   output_q,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [1:0]         cfg_op,
  input  logic [WIDTH-1:0]   cfg_lane,
  input  logic [8:0]         cfg_value,
  output logic               cfg_done,
  input  logic               rdy_odelay,
  output logic               en_vtc,
  output logic [WIDTH*9-1:0] cnt_value_out
);

  localparam logic [8:0]  TMAX  = 9'(TAP_MAX);
  localparam logic [15:0] VLAST = 16'(VTC_WAIT - 1);
  localparam logic [15:0] SLAST = 16'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    OP_LOAD = 2'd0,
    OP_INC  = 2'd1,
    OP_DEC  = 2'd2,
    OP_READ = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_RDY,
    S_VTC_OFF,
    S_APPLY,
    S_SETTLE,
    S_VTC_ON
  } state_e;

  logic [WIDTH-1:0] d1_q, d1_d;
  logic [WIDTH-1:0] d2_q, d2_d;
  logic             ck1_q, ck1_d;
  logic             ck2_q, ck2_d;

  always_comb begin
    d1_d  = input_d1;
    d2_d  = input_d2;
    ck1_d = ~CLOCK_INVERT;
    ck2_d = CLOCK_INVERT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d1_q  <= '0;
      d2_q  <= '0;
      ck1_q <= 1'b0;
      ck2_q <= 1'b0;
    end else begin
      d1_q  <= d1_d;
      d2_q  <= d2_d;
      ck1_q <= ck1_d;
      ck2_q <= ck2_d;
    end
  end

  // Same-edge ODDR: high phase carries d1, low phase carries d2.
  assign output_q   = clk ? d1_q : d2_q;
  assign output_clk = clk ? ck1_q : ck2_q;

  state_e                state_q, state_d;
  logic [15:0]           cnt_q, cnt_d;
  op_e                   op_q, op_d;
  logic [WIDTH-1:0]      lane_q, lane_d;
  logic [8:0]            val_q, val_d;
  logic [WIDTH-1:0][8:0] tap_q, tap_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    lane_d  = lane_q;
    val_d   = val_q;
    tap_d   = tap_q;
    unique case (state_q)
      S_IDLE: begin
        if (cfg_valid) begin
          op_d    = op_e'(cfg_op);
          lane_d  = cfg_lane;
          val_d   = cfg_value;
          state_d = S_WAIT_RDY;
        end
      end
      S_WAIT_RDY: begin
        if (rdy_odelay) begin
          cnt_d   = '0;
          state_d = S_VTC_OFF;
        end
      end
      S_VTC_OFF: begin
        if (cnt_q == VLAST) begin
          cnt_d   = '0;
          state_d = S_APPLY;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_APPLY: begin
        for (int i = 0; i < WIDTH; i++) begin
          if (lane_q[i]) begin
            unique case (op_q)
              OP_LOAD:
                tap_d[i] = (val_q > TMAX) ? TMAX : val_q;
              OP_INC:
                tap_d[i] = (tap_q[i] >= TMAX) ? TMAX
                                              : tap_q[i] + 9'd1;
              OP_DEC:
                tap_d[i] = (tap_q[i] == 9'd0) ? 9'd0
                                              : tap_q[i] - 9'd1;
              default: ;
            endcase
          end
        end
        cnt_d   = '0;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == SLAST) begin
          cnt_d   = '0;
          state_d = S_VTC_ON;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_VTC_ON: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_READ;
      lane_q  <= '0;
      val_q   <= '0;
      tap_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      lane_q  <= lane_d;
      val_q   <= val_d;
      tap_q   <= tap_d;
    end
  end

  assign cfg_ready     = (state_q == S_IDLE) && !rst;
  assign cfg_done      = (state_q == S_VTC_ON) && !rst;
  assign en_vtc        = !((state_q == S_VTC_OFF) ||
                           (state_q == S_APPLY) ||
                           (state_q == S_SETTLE));
  assign cnt_value_out = tap_q;

endmodule

// File: tb/tb_ssio_ddr_out.sv
// tb_ssio_ddr_out: directed checks of DDR data/clock path and
// tap-control sequencing, saturation, stalls, back-to-back and reset.
module tb_ssio_ddr_out;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  d1, d2;
  logic        valid;
  logic [1:0]  op;
  logic [3:0]  lane;
  logic [8:0]  val;
  logic        rdy;

  logic        oclk0, oclk1;
  logic [3:0]  q0, q1;
  logic        ready0, ready1;
  logic        done0, done1;
  logic        vtc0, vtc1;
  logic [35:0] cnt0, cnt1;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ssio_ddr_out #(.WIDTH(4), .CLOCK_INVERT(1'b0)) u_dut0 (
    .clk(clk), .rst(rst),
    .input_d1(d1), .input_d2(d2),
    .output_clk(oclk0), .output_q(q0),
    .cfg_valid(valid), .cfg_ready(ready0),
    .cfg_op(op), .cfg_lane(lane), .cfg_value(val),
    .cfg_done(done0), .rdy_odelay(rdy),
    .en_vtc(vtc0), .cnt_value_out(cnt0)
  );

  ssio_ddr_out #(.WIDTH(4), .CLOCK_INVERT(1'b1),
                 .TAP_MAX(300)) u_dut1 (
    .clk(clk), .rst(rst),
    .input_d1(d1), .input_d2(d2),
    .output_clk(oclk1), .output_q(q1),
    .cfg_valid(valid), .cfg_ready(ready1),
    .cfg_op(op), .cfg_lane(lane), .cfg_value(val),
    .cfg_done(done1), .rdy_odelay(rdy),
    .en_vtc(vtc1), .cnt_value_out(cnt1)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [35:0] pk(input logic [8:0] a3,
                                     input logic [8:0] a2,
                                     input logic [8:0] a1,
                                     input logic [8:0] a0);
    return {a3, a2, a1, a0};
  endfunction

  task automatic hi();
    @(posedge clk); #2;
  endtask

  task automatic lo();
    @(negedge clk); #2;
  endtask

  task automatic issue(input logic [1:0] o,
                       input logic [3:0] m,
                       input logic [8:0] v);
    int n;
    n = 0;
    lo();
    while (!ready0 && n < 100) begin
      lo();
      n++;
    end
    chk("ready_to", {63'd0, ready0}, 64'd1);
    valid = 1'b1;
    op    = o;
    lane  = m;
    val   = v;
    hi();
    valid = 1'b0;
  endtask

  task automatic wait_done(output int lows);
    int n;
    lows = 0;
    n    = 0;
    do begin
      lo();
      if (!vtc0) lows++;
      n++;
    end while (!done0 && n < 200);
    chk("done_to", {63'd0, done0}, 64'd1);
  endtask

  task automatic req(input logic [1:0] o,
                     input logic [3:0] m,
                     input logic [8:0] v,
                     input string tag);
    int lows;
    issue(o, m, v);
    wait_done(lows);
    chk(tag, lows, 19);
  endtask

  initial begin
    int  lows, n, xf, dn;
    bit  ok;

    rst   = 1'b1;
    valid = 1'b0;
    op    = 2'd0;
    lane  = 4'd0;
    val   = 9'd0;
    rdy   = 1'b1;
    d1    = 4'h0;
    d2    = 4'h0;
    repeat (3) hi();
    chk("rst_q", q0, 4'h0);
    chk("rst_vtc", vtc0, 1);
    chk("rst_ready", ready0, 0);
    chk("rst_done", done0, 0);
    chk("rst_cnt", cnt0, 0);

    lo();
    chk("rst_q_lo", q0, 4'h0);
    rst = 1'b0;
    d1  = 4'hF;
    d2  = 4'h0;
    hi();
    chk("q_hi_F", q0, 4'hF);
    chk("oclk_hi", oclk0, 1);
    chk("oclk_inv_hi", oclk1, 0);
    lo();
    chk("q_lo_0", q0, 4'h0);
    chk("oclk_lo", oclk0, 0);
    chk("oclk_inv_lo", oclk1, 1);
    chk("ready_idle", ready0, 1);
    d1 = 4'hA;
    d2 = 4'h5;
    hi();
    chk("q_hi_A", q0, 4'hA);
    lo();
    chk("q_lo_5", q0, 4'h5);
    d1 = 4'h3;
    d2 = 4'hC;
    #1;
    chk("q_latency", q0, 4'h5);
    hi();
    chk("q_hi_3", q0, 4'h3);
    chk("q_hi_3_d1", q1, 4'h3);
    lo();
    chk("q_lo_C", q0, 4'hC);

    issue(2'd0, 4'b0101, 9'd100);
    wait_done(lows);
    chk("load_lows", lows, 19);
    chk("load_cnt", cnt0, pk(0, 100, 0, 100));
    lo();
    chk("done_single", done0, 0);

    req(2'd0, 4'b0010, 9'd511, "l511_lows");
    chk("l511", cnt0, pk(0, 100, 511, 100));
    chk("l511_t300", cnt1[17:9], 300);
    req(2'd1, 4'b0010, 9'd0, "inc_sat_lows");
    chk("inc_sat", cnt0[17:9], 511);
    chk("inc_sat_t300", cnt1[17:9], 300);

    req(2'd0, 4'b0001, 9'd0, "l0_lows");
    req(2'd2, 4'b0001, 9'd0, "dec_sat_lows");
    chk("dec_sat", cnt0, pk(0, 100, 511, 0));

    req(2'd0, 4'b1000, 9'd400, "l400_lows");
    chk("l400", cnt0[35:27], 400);
    chk("l400_clamp", cnt1[35:27], 300);
    req(2'd1, 4'b1000, 9'd0, "inc401_lows");
    chk("inc401", cnt0[35:27], 401);
    chk("inc_clamp", cnt1[35:27], 300);

    req(2'd3, 4'b1111, 9'd7, "rb_lows");
    chk("readback", cnt0, pk(401, 100, 511, 0));
    req(2'd1, 4'b0000, 9'd0, "zmask_lows");
    chk("zero_mask", cnt0, pk(401, 100, 511, 0));

    rdy = 1'b0;
    issue(2'd1, 4'b0100, 9'd0);
    ok = 1'b1;
    repeat (20) begin
      lo();
      if (!vtc0 || ready0 || done0) ok = 1'b0;
    end
    chk("wait_rdy_hold", {63'd0, ok}, 64'd1);
    rdy = 1'b1;
    wait_done(lows);
    chk("wait_rdy_lows", lows, 19);
    chk("wait_rdy_cnt", cnt0, pk(401, 101, 511, 0));

    n = 0;
    lo();
    while (!ready0 && n < 100) begin
      lo();
      n++;
    end
    valid = 1'b1;
    op    = 2'd1;
    lane  = 4'b0001;
    val   = 9'd0;
    xf = 0;
    dn = 0;
    n  = 0;
    #1;
    while (dn < 3 && n < 400) begin
      if (done0) dn++;
      if (ready0 && valid) begin
        xf++;
        if (xf == 3) begin
          hi();
          valid = 1'b0;
        end
      end
      lo();
      n++;
    end
    chk("b2b_xfers", xf, 3);
    chk("b2b_dones", dn, 3);
    chk("b2b_cnt", cnt0[8:0], 3);
    ok = 1'b1;
    repeat (30) begin
      lo();
      if (done0 || !ready0) ok = 1'b0;
    end
    chk("b2b_quiet", {63'd0, ok}, 64'd1);
    chk("b2b_cnt2", cnt0, pk(401, 101, 511, 3));

    issue(2'd1, 4'b0010, 9'd0);
    lows = 0;
    n    = 0;
    while (lows < 14 && n < 200) begin
      lo();
      if (!vtc0) lows++;
      n++;
    end
    chk("settle_reach", lows, 14);
    rst = 1'b1;
    hi();
    chk("mrst_vtc", vtc0, 1);
    chk("mrst_cnt", cnt0, 0);
    chk("mrst_done", done0, 0);
    lo();
    rst = 1'b0;
    hi();
    chk("mrst_ready", ready0, 1);
    ok = 1'b1;
    repeat (30) begin
      lo();
      if (done0 || !vtc0) ok = 1'b0;
    end
    chk("mrst_no_done", {63'd0, ok}, 64'd1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
